eth_rx_frame_writer: RTL and testbench
======================================

Name: eth_rx_frame_writer

Overview:
- Upstream stage of the 512x8 single-port RX buffer RAM in the Nios Ethernet subsystem.
- Accepts a byte stream from the MAC receive path and writes one frame at a time into the buffer, starting at address 0.
- Reports frame length and ready status to the CPU, which reads the RAM and then acks.
- Drops frames that are oversized, errored, truncated by a new SOP, or arrive while the buffer is occupied; counts the drops.

Parameters:
ADDR_W, 9, RAM address width
DEPTH, 512, buffer size in bytes; maximum accepted frame length
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid this cycle; no backpressure, every valid byte must be consumed
rx_sop  in  1  first byte of frame; qualified by rx_valid
rx_eop  in  1  last byte of frame; qualified by rx_valid
rx_err  in  1  frame error (CRC/PHY); sampled only with rx_valid&rx_eop
ram_address  out  ADDR_W  RAM write address
ram_chipselect  out  1  RAM chipselect
ram_write  out  1  RAM write strobe
ram_writedata  out  8  RAM write data
frame_ready  out  1  a complete good frame is held in the RAM
frame_len  out  ADDR_W+1  byte count of the held frame, 1..DEPTH
frame_ack  in  1  CPU has finished with the frame; single-cycle pulse
drop_cnt  out  CNT_W  count of dropped frames; saturates at all-ones
drop_clr  in  1  synchronous clear of drop_cnt

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; all outputs 0; byte counter 0.
  - Reset mid-frame abandons the frame without counting a drop.
- RAM port: ram_chipselect=ram_write, both registered.
  - Each accepted byte is written one cycle after it arrives at the input: ram_address = byte index within the frame, ram_writedata = byte.
  - No write occurs in any other cycle.
- States: IDLE, RECV, DONE, DROP.
- IDLE:
  - rx_valid&rx_sop: write byte at address 0, count=1.
    - If rx_eop is also set and rx_err=0: go to DONE, frame_len=1.
    - If rx_eop is also set and rx_err=1: drop, stay IDLE.
    - Otherwise go to RECV.
  - Valid bytes without sop are ignored and not counted.
- RECV, on each rx_valid:
  - rx_sop set: abort the current frame, drop_cnt+1, then treat the byte as a new frame's first byte (address 0, as in IDLE).
  - count==DEPTH: no write, drop_cnt+1.
    - Go to IDLE if rx_eop is set, else go to DROP.
  - Otherwise write at address count, count+1.
    - On rx_eop with rx_err=0: go to DONE, frame_len=count+1.
    - On rx_eop with rx_err=1: drop_cnt+1, go to IDLE.
  - Cycles without rx_valid: hold state.
- DONE:
  - frame_ready=1 and frame_len is stable; no RAM writes.
  - frame_ack: frame_ready falls on the next edge, go to IDLE.
  - rx_valid&rx_sop without ack: drop_cnt+1.
    - If rx_eop is also set, stay DONE; else go to DROP with return target DONE.
  - frame_ack and rx_valid&rx_sop in the same cycle: the ack wins and the new frame is accepted exactly as in IDLE, so no bytes are lost. frame_ready falls, or stays 1 if that byte is also a good eop.
- DROP:
  - Discard bytes until rx_valid&rx_eop, then return to the return target: IDLE, or DONE if the drop started in DONE.
  - frame_ack while dropping from DONE: clear frame_ready and change the return target to IDLE.
  - rx_sop in DROP: that frame is also discarded; no extra count. The dropped frame is still counted once.
- frame_ack in IDLE/RECV is ignored.
- drop_cnt saturates at 2^CNT_W-1.
  - drop_clr has priority over a same-cycle increment; the result is 0.
- frame_len holds its last value until the next frame completes.

Test Plan:
- Good 64-byte frame 0x00..0x3F, rx_valid continuous → 64 writes at addresses 0..63 with matching data; frame_ready=1 one cycle after the eop write is issued; frame_len=64; drop_cnt=0.
- 513-byte frame → 512 writes (addresses 0..511), byte 513 not written, frame_ready=0, drop_cnt=1; a following 10-byte frame gives frame_len=10.
- Frame with rx_err at eop, then frame_ack with no frame held → frame_ready stays 0, drop_cnt=1; the ack has no effect.
- Frame held in DONE, second 20-byte frame arrives → no RAM writes, drop_cnt=1, frame_len unchanged; frame_ack + rx_sop in the same cycle then accepts the third frame from address 0.
- Mid-frame rx_sop after 5 bytes, then a 3-byte frame → drop_cnt=1, frame_len=3, writes at addresses 0..2. Separately, reset_n=0 mid-frame → all outputs 0, drop_cnt=0.
- Force drop_cnt to 0xFFFF with another drop → stays 0xFFFF; drop_clr together with a drop → 0.

Source files
------------

// File: rtl/eth_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_writer
// Purpose  : Writes one received Ethernet frame at a time into the 512x8 RX
//            buffer RAM, reports length/ready to the CPU and counts drops.
// Revision : 1.0  initial release
// ============================================================================
module eth_rx_frame_writer #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [7:0]        ram_writedata,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  input  logic              frame_ack,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              drop_clr
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] C_DEPTH = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] C_ONE   = LEN_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              ret_done_q, ret_done_d;   // DROP returns to DONE
  logic [LEN_W-1:0]  count_q, count_d;         // bytes written this frame
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [7:0]        ram_writedata_q, ram_writedata_d;
  logic              frame_ready_q, frame_ready_d;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Shared decode of the current byte
  logic       w_sop_v;
  logic       w_first;     // byte starts a new frame at address 0
  logic       w_next;      // byte continues the current frame
  logic       w_full;      // byte would overflow the buffer
  logic       w_take;
  logic [1:0] w_inc;
  logic [CNT_W:0] w_sum;

  assign w_sop_v = rx_valid & rx_sop;
  assign w_first = w_sop_v & ((state_q == S_IDLE) | (state_q == S_RECV) |
                              ((state_q == S_DONE) & frame_ack));
  assign w_next  = rx_valid & ~rx_sop & (state_q == S_RECV) & (count_q != C_DEPTH);
  assign w_full  = rx_valid & ~rx_sop & (state_q == S_RECV) & (count_q == C_DEPTH);
  assign w_take  = w_first | w_next;

  // Drops this cycle: an abort by a new SOP can coincide with an errored
  // single-byte replacement frame, hence a two-bit increment.
  assign w_inc = 2'(w_sop_v & (state_q == S_RECV))
               + 2'(w_take & rx_eop & rx_err)
               + 2'(w_full)
               + 2'(w_sop_v & (state_q == S_DONE) & ~frame_ack);
  assign w_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(w_inc);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      ret_done_q      <= 1'b0;
      count_q         <= '0;
      ram_write_q     <= 1'b0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
      frame_ready_q   <= 1'b0;
      frame_len_q     <= '0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      ret_done_q      <= ret_done_d;
      count_q         <= count_d;
      ram_write_q     <= ram_write_d;
      ram_address_q   <= ram_address_d;
      ram_writedata_q <= ram_writedata_d;
      frame_ready_q   <= frame_ready_d;
      frame_len_q     <= frame_len_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // Next-state, return target and byte counter
  always_comb begin
    state_d    = state_q;
    ret_done_d = ret_done_q;
    count_d    = count_q;
    if (w_first) begin
      count_d = C_ONE;
      state_d = rx_eop ? (rx_err ? S_IDLE : S_DONE) : S_RECV;
    end else begin
      case (state_q)
        S_RECV: begin
          if (w_full) begin
            state_d    = rx_eop ? S_IDLE : S_DROP;
            ret_done_d = 1'b0;
          end else if (w_next) begin
            count_d = count_q + C_ONE;
            if (rx_eop) state_d = rx_err ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            state_d = S_IDLE;
          end else if (w_sop_v && !rx_eop) begin
            state_d    = S_DROP;
            ret_done_d = 1'b1;
          end
        end
        S_DROP: begin
          if (frame_ack) ret_done_d = 1'b0;
          if (rx_valid && rx_eop) state_d = (ret_done_q && !frame_ack) ? S_DONE : S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // RAM write, frame status and drop counter updates
  always_comb begin
    ram_write_d     = w_take;
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    frame_len_d     = frame_len_q;
    frame_ready_d   = 1'b0;
    if (w_take) begin
      ram_address_d   = w_first ? '0 : count_q[ADDR_W-1:0];
      ram_writedata_d = rx_data;
      if (rx_eop && !rx_err) frame_len_d = w_first ? C_ONE : count_q + C_ONE;
    end
    // Ready follows the held frame one cycle after its last write; an ack
    // clears it at once unless the same byte completes a 1-byte frame.
    case (state_q)
      S_DONE:  frame_ready_d = frame_ack ? (w_first & rx_eop & ~rx_err) : 1'b1;
      S_DROP:  frame_ready_d = ret_done_q & ~frame_ack;
      default: frame_ready_d = 1'b0;
    endcase
    if (drop_clr)         drop_cnt_d = '0;
    else if (w_sum[CNT_W]) drop_cnt_d = '1;
    else                  drop_cnt_d = w_sum[CNT_W-1:0];
  end

  assign ram_write      = ram_write_q;
  assign ram_chipselect = ram_write_q;
  assign ram_address    = ram_address_q;
  assign ram_writedata  = ram_writedata_q;
  assign frame_ready    = frame_ready_q;
  assign frame_len      = frame_len_q;
  assign drop_cnt       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_frame_writer
// Purpose  : Self-checking bench for eth_rx_frame_writer against a
//            frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_frame_writer;

  localparam int DEPTH  = 512;
  localparam int CNTMAX = 65535;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
  logic       frame_ack = 1'b0, drop_clr = 1'b0;
  logic [8:0] ram_address;
  logic       ram_chipselect, ram_write;
  logic [7:0] ram_writedata;
  logic       frame_ready;
  logic [9:0] frame_len;
  logic [15:0] drop_cnt;

  eth_rx_frame_writer #(.ADDR_W(9), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .frame_ready(frame_ready), .frame_len(frame_len),
    .frame_ack(frame_ack), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  // Reference model: mode 0 = between frames, 1 = collecting, 2 = discarding.
  // m_held says a good frame sits in the buffer, independent of the mode.
  int m_mode = 0;
  bit m_held = 0;
  int m_n    = 0;
  bit e_we = 0;
  int e_addr = 0, e_data = 0, e_len = 0, e_cnt = 0;
  bit e_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Store the current byte at index idx of the frame being collected
  task automatic take(input int idx, inout int inc);
    e_we   = 1;
    e_addr = idx;
    e_data = int'(rx_data);
    m_n    = idx + 1;
    if (rx_eop) begin
      m_mode = 0;
      if (rx_err) inc++;
      else begin
        m_held = 1;
        e_len  = m_n;
      end
    end else begin
      m_mode = 1;
    end
  endtask

  task automatic model_step();
    bit held_before;
    int inc;
    if (!reset_n) begin
      m_mode = 0; m_held = 0; m_n = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_ready = 0; e_len = 0; e_cnt = 0;
      return;
    end
    held_before = m_held;
    inc  = 0;
    e_we = 0;
    if (frame_ack && m_held) m_held = 0;
    if (rx_valid) begin
      case (m_mode)
        2: if (rx_eop) m_mode = 0;
        1: begin
          if (rx_sop) begin
            inc++;
            take(0, inc);
          end else if (m_n == DEPTH) begin
            inc++;
            m_mode = rx_eop ? 0 : 2;
          end else begin
            take(m_n, inc);
          end
        end
        default: begin
          if (rx_sop) begin
            if (m_held) begin
              inc++;
              m_mode = rx_eop ? 0 : 2;
            end else begin
              take(0, inc);
            end
          end
        end
      endcase
    end
    e_ready = held_before && m_held;
    if (drop_clr) e_cnt = 0;
    else e_cnt = (e_cnt + inc > CNTMAX) ? CNTMAX : e_cnt + inc;
  endtask

  task automatic compare();
    chk("ram_write", int'(ram_write), int'(e_we));
    chk("ram_chipselect", int'(ram_chipselect), int'(e_we));
    if (e_we) begin
      chk("ram_address", int'(ram_address), e_addr);
      chk("ram_writedata", int'(ram_writedata), e_data);
    end
    chk("frame_ready", int'(frame_ready), int'(e_ready));
    chk("frame_len", int'(frame_len), e_len);
    chk("drop_cnt", int'(drop_cnt), e_cnt);
    if (ram_write) wr_count++;
  endtask

  // One clock: apply inputs, advance the model, check after the edge
  task automatic step(input bit v, input bit s, input bit e, input bit er,
                      input logic [7:0] d, input bit ack, input bit clr, input bit rn);
    rx_valid = v; rx_sop = s; rx_eop = e; rx_err = er; rx_data = d;
    frame_ack = ack; drop_clr = clr; reset_n = rn;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, 0, 1);
  endtask

  task automatic sendf(input int len, input bit err, input bit with_eop, input logic [7:0] base);
    for (int i = 0; i < len; i++)
      step(1, i == 0, with_eop && (i == len - 1), err && (i == len - 1),
           base + 8'(i), 0, 0, 1);
  endtask

  initial begin
    int rem;
    bit v, s, e, er, ack, clr, rn;

    // Reset
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 0, 0, 0);
    chk("rst_ready", int'(frame_ready), 0);
    chk("rst_write", int'(ram_write), 0);
    chk("rst_len", int'(frame_len), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // Good 64-byte frame 0x00..0x3F
    wr_count = 0;
    sendf(64, 0, 1, 8'h00);
    chk("f64_last_addr", int'(ram_address), 63);
    chk("f64_last_data", int'(ram_writedata), 8'h3F);
    chk("f64_ready_not_yet", int'(frame_ready), 0);
    idle(1);
    chk("f64_ready", int'(frame_ready), 1);
    chk("f64_len", int'(frame_len), 64);
    chk("f64_writes", wr_count, 64);
    chk("f64_drop", int'(drop_cnt), 0);
    step(0, 0, 0, 0, 8'h00, 1, 0, 1);
    chk("f64_ack", int'(frame_ready), 0);

    // Oversized 513-byte frame, then 10-byte frame
    wr_count = 0;
    sendf(513, 0, 1, 8'h10);
    idle(2);
    chk("big_writes", wr_count, 512);
    chk("big_ready", int'(frame_ready), 0);
    chk("big_drop", int'(drop_cnt), 1);
    sendf(10, 0, 1, 8'h80);
    idle(2);
    chk("f10_len", int'(frame_len), 10);
    chk("f10_ready", int'(frame_ready), 1);
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);

    // Errored frame, then a stray ack
    sendf(6, 1, 1, 8'h20);
    idle(1);
    step(0, 0, 0, 0, 8'h00, 1, 0, 1);
    idle(1);
    chk("err_ready", int'(frame_ready), 0);
    chk("err_drop", int'(drop_cnt), 1);
    chk("err_len", int'(frame_len), 10);

    // Held frame, colliding frame, then ack+sop replacement
    sendf(8, 0, 1, 8'h30);
    idle(2);
    step(0, 0, 0, 0, 8'h00, 0, 1, 1);
    wr_count = 0;
    sendf(20, 0, 1, 8'h40);
    idle(2);
    chk("coll_writes", wr_count, 0);
    chk("coll_drop", int'(drop_cnt), 1);
    chk("coll_len", int'(frame_len), 8);
    chk("coll_ready", int'(frame_ready), 1);
    step(1, 1, 0, 0, 8'hA0, 1, 0, 1);
    chk("ackSop_write", int'(ram_write), 1);
    chk("ackSop_addr", int'(ram_address), 0);
    chk("ackSop_ready", int'(frame_ready), 0);
    for (int i = 1; i < 4; i++) step(1, 0, i == 3, 0, 8'hA0 + 8'(i), 0, 0, 1);
    idle(2);
    chk("ackSop_len", int'(frame_len), 4);
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);

    // Mid-frame SOP truncation
    wr_count = 0;
    sendf(5, 0, 0, 8'h50);
    sendf(3, 0, 1, 8'h60);
    idle(2);
    chk("trunc_drop", int'(drop_cnt), 1);
    chk("trunc_len", int'(frame_len), 3);
    chk("trunc_writes", wr_count, 8);
    step(0, 0, 0, 0, 8'h00, 1, 0, 1);

    // Reset mid-frame
    sendf(4, 0, 0, 8'h70);
    step(1, 0, 0, 0, 8'h74, 0, 0, 0);
    chk("rstmid_write", int'(ram_write), 0);
    chk("rstmid_len", int'(frame_len), 0);
    chk("rstmid_drop", int'(drop_cnt), 0);
    idle(2);

    // Randomized traffic
    rem = 0;
    for (int c = 0; c < 6000; c++) begin
      v = ($urandom % 4) != 0; s = 0; e = 0; er = 0;
      if (v) begin
        if (rem == 0) begin
          if ($urandom % 16 == 0) e = 1'($urandom % 2);
          else begin
            s = 1;
            rem = ($urandom % 25 == 0) ? int'($urandom_range(505, 520)) : int'($urandom_range(1, 40));
          end
        end else if ($urandom % 40 == 0) begin
          s = 1;
          rem = int'($urandom_range(1, 40));
        end
        if (rem > 0) begin
          e = (rem == 1);
          rem--;
        end
        er = e && ($urandom % 6 == 0);
      end
      ack = ($urandom % 12) == 0;
      clr = ($urandom % 300) == 0;
      rn  = ($urandom % 1500) != 0;
      step(v, s, e, er, 8'($urandom), ack, clr, rn);
    end
    idle(2);

    // Saturation: every SOP inside a frame aborts it and counts a drop
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);
    step(1, 1, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < CNTMAX + 2; i++) step(1, 1, 0, 0, 8'(i), 0, 0, 1);
    chk("sat_drop", int'(drop_cnt), CNTMAX);
    step(1, 1, 0, 0, 8'h11, 0, 1, 1);
    chk("clr_with_drop", int'(drop_cnt), 0);
    step(1, 0, 1, 0, 8'h22, 0, 0, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
